// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state type and access-size helper for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_e;

  // funct3[1:0] encodes log2 of the access size in bytes
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane placement, byte enables and load extract/extend
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        funct3_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [DATA_W-1:0] st_lane_o,
  output logic [NB-1:0]     be_o,
  input  logic [DATA_W-1:0] ld_word_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] shifted;

  // Replicating the item across lanes already lands it at every aligned offset
  always_comb begin
    st_lane_o = st_data_i;
    size_mask = '1;
    case (funct3_i[1:0])
      2'b00: begin
        st_lane_o = {NB{st_data_i[7:0]}};
        size_mask = NB'(8'h01);
      end
      2'b01: begin
        st_lane_o = {(NB/2){st_data_i[15:0]}};
        size_mask = NB'(8'h03);
      end
      2'b10: begin
        st_lane_o = {(NB/4){st_data_i[31:0]}};
        size_mask = NB'(8'h0F);
      end
      default: begin
        st_lane_o = st_data_i;
        size_mask = '1;
      end
    endcase
  end

  assign be_o    = size_mask << offset_i;
  assign shifted = ld_word_i >> {offset_i, 3'b000};

  always_comb begin
    ld_data_o = shifted;
    case (funct3_i)
      F3_B:    ld_data_o = DATA_W'($signed(shifted[7:0]));
      F3_H:    ld_data_o = DATA_W'($signed(shifted[15:0]));
      F3_W:    ld_data_o = DATA_W'($signed(shifted[31:0]));
      F3_BU:   ld_data_o = DATA_W'(shifted[7:0]);
      F3_HU:   ld_data_o = DATA_W'(shifted[15:0]);
      F3_WU:   ld_data_o = DATA_W'(shifted[31:0]);
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_handshake.sv
// rtl/lsu_handshake.sv - valid/ack load/store unit with misalign detection, timeout and core stall
module lsu_handshake
  import lsu_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 9,
  parameter  int TIMEOUT = 16,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    stall,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    misalign,
  output logic                    timeout_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-OFF_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]           mem_be_q, mem_be_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic                    misalign_q, misalign_d, tout_q, tout_d;
  logic [2:0]              f3_q, f3_d;
  logic [OFF_W-1:0]        off_q, off_d;

  logic             legal, aligned;
  logic [3:0]       sz_m1;
  logic [2:0]       al_f3;
  logic [OFF_W-1:0] al_off;
  logic [NB-1:0]    al_be;
  logic [DATA_W-1:0] al_st, al_ld;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_D:             legal = (DATA_W == 64);
      F3_BU, F3_HU:     legal = ~req_we;
      F3_WU:            legal = ~req_we & (DATA_W == 64);
      default:          legal = 1'b0;
    endcase
  end

  assign sz_m1   = size_bytes(req_funct3) - 4'd1;
  assign aligned = ((req_addr[OFF_W-1:0] & sz_m1[OFF_W-1:0]) == '0);

  // One aligner serves both phases: live request in IDLE, latched op while waiting
  assign al_f3  = (state_q == IDLE) ? req_funct3 : f3_q;
  assign al_off = (state_q == IDLE) ? req_addr[OFF_W-1:0] : off_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3_i  (al_f3),
    .offset_i  (al_off),
    .st_data_i (req_wdata),
    .st_lane_o (al_st),
    .be_o      (al_be),
    .ld_word_i (mem_rdata),
    .ld_data_o (al_ld)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;
    tout_d      = tout_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (legal && aligned) begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[ADDR_W-1:OFF_W];
            mem_be_d    = al_be;
            mem_wdata_d = req_we ? al_st : '0;
            f3_d        = req_funct3;
            off_d       = req_addr[OFF_W-1:0];
            cnt_d       = '0;
            state_d     = WAIT;
          end else begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      WAIT: begin
        if (mem_ack || (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          rdata_d     = (mem_ack && !mem_we_q) ? al_ld : '0;
          tout_d      = ~mem_ack;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        rdata_d    = '0;
        misalign_d = 1'b0;
        tout_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      tout_q      <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      tout_q      <= tout_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign resp_valid  = (state_q == DONE);
  assign stall       = req_valid & ~resp_valid;
  assign resp_rdata  = rdata_q;
  assign misalign    = misalign_q;
  assign timeout_err = tout_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
